// File: rtl/bit_column_encoder.sv
// Bit-serial weight column encoder: latches a weight/activation vector pair and emits one encoded bit column per beat.
// Latency: first column valid the cycle after acceptance; emitted columns follow back to back, and all-zero columns cost no cycles.
// Backpressure: column outputs hold while col_valid && !col_ready; a new vector is accepted in IDLE or on consumption of the last column.
module bit_column_encoder #(
   parameter int DATA_WIDTH    = 8,
   parameter int VEC_LENGTH    = 32,
   parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1,
   parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH - 2,
   parameter bit SKIP_ZERO_COL = 1'b1
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]         weight,
   input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]         act,
   output logic                                          col_valid,
   input  logic                                          col_ready,
   output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]         act_out,
   output logic [VEC_LENGTH/2-1:0][MUX_SEL_WIDTH-3:0]    act_sel,
   output logic [VEC_LENGTH/8-1:0][SUM_ACT_WIDTH-1:0]    sum_act,
   output logic [VEC_LENGTH/8-1:0]                       is_skip_zero,
   output logic [2:0]                                    column_idx,
   output logic                                          is_msb,
   output logic                                          first_col,
   output logic                                          last_col
);

   localparam int NG    = VEC_LENGTH / 8;
   localparam int SEL_W = MUX_SEL_WIDTH - 2;
   localparam int EXT_W = SUM_ACT_WIDTH - DATA_WIDTH;

   typedef enum logic {IDLE, RUN} state_t;

   state_t state, state_nxt;

   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_q;
   logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] src_w;
   logic [2:0]                            nxt_col;
   logic [VEC_LENGTH/2-1:0][SEL_W-1:0]    nxt_sel;
   logic [NG-1:0]                         nxt_skip;
   logic [NG-1:0][SUM_ACT_WIDTH-1:0]      nxt_sum;
   logic                                  do_load;
   logic                                  advance;
   int                                    start;

   assign col_valid = (state == RUN);
   assign advance   = col_valid && col_ready;
   assign in_ready  = (state == IDLE) || (advance && last_col);
   assign do_load   = in_valid && in_ready;

   // Search source: fresh weights on a load, latched weights when stepping to the next column.
   always_comb begin
      src_w = w_q;
      start = int'(column_idx) + 1;
      if (do_load) begin
         src_w = weight;
         start = 0;
      end
   end

   // Lowest column at or above start that is non-zero (or unconditional when skipping is off); MSB column always qualifies.
   always_comb begin
      logic col_any;
      col_any = 1'b0;
      nxt_col = 3'(DATA_WIDTH - 1);
      for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
         col_any = 1'b0;
         for (int k = 0; k < VEC_LENGTH; k++) begin
            col_any = col_any | src_w[k][c];
         end
         if ((c >= start) && (col_any || !SKIP_ZERO_COL || (c == DATA_WIDTH - 1))) begin
            nxt_col = 3'(c);
         end
      end
   end

   // Per-group polarity choice and slot fill: the i-th selected bit position goes to slot i, unused slots read 8 (mux zero).
   always_comb begin
      int   ones;
      int   rank;
      logic pol;
      ones     = 0;
      rank     = 0;
      pol      = 1'b0;
      nxt_sel  = {(VEC_LENGTH/2){SEL_W'(8)}};
      nxt_skip = '0;
      for (int g = 0; g < NG; g++) begin
         ones = 0;
         for (int k = 0; k < 8; k++) begin
            ones = ones + int'(src_w[8*g+k][nxt_col]);
         end
         pol         = (ones <= 4);
         nxt_skip[g] = pol;
         rank        = 0;
         for (int k = 0; k < 8; k++) begin
            if (src_w[8*g+k][nxt_col] == pol) begin
               for (int j = 0; j < 4; j++) begin
                  if (rank == j) begin
                     nxt_sel[4*g+j] = SEL_W'(k);
                  end
               end
               rank = rank + 1;
            end
         end
      end
   end

   // Signed sum of each group's eight incoming activations.
   always_comb begin
      nxt_sum = '0;
      for (int g = 0; g < NG; g++) begin
         for (int k = 0; k < 8; k++) begin
            nxt_sum[g] = nxt_sum[g] + {{EXT_W{act[8*g+k][DATA_WIDTH-1]}}, act[8*g+k]};
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a load always enters RUN; consuming the last column without a reload returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (do_load) state_nxt = RUN;
         end
         RUN: begin
            if (do_load) begin
               state_nxt = RUN;
            end else if (advance && last_col) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Vector latch and column output registers; outputs only move on a load or on consuming a non-last column.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q          <= '0;
         act_out      <= '0;
         sum_act      <= '0;
         act_sel      <= {(VEC_LENGTH/2){SEL_W'(8)}};
         is_skip_zero <= '0;
         column_idx   <= '0;
         is_msb       <= 1'b0;
         first_col    <= 1'b0;
         last_col     <= 1'b0;
      end else if (do_load || (advance && !last_col)) begin
         if (do_load) begin
            w_q     <= weight;
            act_out <= act;
            sum_act <= nxt_sum;
         end
         column_idx   <= nxt_col;
         act_sel      <= nxt_sel;
         is_skip_zero <= nxt_skip;
         is_msb       <= (nxt_col == 3'(DATA_WIDTH - 1));
         last_col     <= (nxt_col == 3'(DATA_WIDTH - 1));
         first_col    <= do_load;
      end
   end

endmodule
